tone_sequencer: RTL
===================

# tone_sequencer

Programmable step sequencer that drives the 8-bit tone-select bus of the modulator stage (its `data_in`). It holds a small pattern memory of tone masks, one mask per step, and plays the steps in order. Each step lasts a programmed number of prescaled ticks, with an optional silent gap between steps. It supports one-shot or looped playback, and the pattern is written through a valid/ready port while idle.

## Interface
Parameters:
- `STEPS`, 16: pattern depth; power of two; address width `AW = log2(STEPS)`.
- `TICK_DIV`, 25000: clock cycles per tick; ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_valid`  in  1  pattern write request.
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready`.
- `wr_addr`  in  AW  step index to write.
- `wr_data`  in  8  tone mask for that step (bit i enables tone i).
- `len`  in  AW  index of the last active step; play steps 0..len.
- `step_ticks`  in  8  ticks per step; 0 is treated as 1.
- `gap_ticks`  in  8  silent ticks after each step; 0 means no gap.
- `loop`  in  1  1 = wrap to step 0 after step `len`.
- `start`  in  1  single-cycle start request.
- `stop`  in  1  single-cycle abort request.
- `tones`  out  8  tone mask to the modulator.
- `step_idx`  out  AW  current step.
- `busy`  out  1  high in PLAY or GAP.
- `done`  out  1  one-cycle pulse on natural completion.

## Operation
- **Reset values:**
  - State is IDLE.
  - Pattern memory is cleared to all zero.
  - `tones`=0, `step_idx`=0, `busy`=0, `done`=0.
  - Prescaler and tick counter are 0.
- **States:** IDLE, PLAY, GAP.
- **Write port:**
  - `wr_ready = (state==IDLE) & !start`, combinational.
  - An accepted write updates memory at the clock edge.
  - Writes are refused while busy.
- **IDLE → PLAY** on `start & !stop`:
  - Latch `len`, `step_ticks`, `gap_ticks` and `loop`. Later changes to these inputs have no effect until the next start.
  - Set `step_idx`=0 and `tones`=pattern[0].
  - Clear the prescaler and tick counter.
- **Prescaler:**
  - Counts 0..TICK_DIV-1 only while busy.
  - Emits a one-cycle tick on wrap.
- **PLAY:**
  - Count ticks.
  - At the tick that reaches the effective step length (`max(step_ticks,1)`):
    - If `gap_ticks`≠0: go to GAP, set `tones`=0, clear the tick counter.
    - Otherwise: advance.
- **GAP:** after `gap_ticks` ticks, advance.
- **Advance:**
  - If `step_idx` < `len`: increment `step_idx`, load `tones`=pattern[step_idx+1], enter PLAY.
  - Else if `loop`: set `step_idx`=0, load pattern[0], enter PLAY.
  - Else: go to IDLE, set `tones`=0, pulse `done` for one cycle. `step_idx` holds its last value until the next start.
- **`stop`** in any state:
  - Go to IDLE on the next edge with `tones`=0.
  - No `done` pulse.
  - The prescaler is cleared.
- **Simultaneous events:**
  - `start` while busy is ignored.
  - `start & stop` in IDLE: stop wins and the sequencer stays in IDLE.
  - `stop` in the same cycle as a natural completion: no `done`.
- Pattern contents are unaffected by start, stop or playback.

## Timing
- `start` sampled at edge N: `busy`=1 and `tones`=pattern[0] from N+1.
- **Step length:** step k drives `tones` for exactly `max(step_ticks,1)·TICK_DIV` cycles. The gap follows for `gap_ticks·TICK_DIV` cycles with `tones`=0.
- Consecutive steps with no gap change `tones` on a single edge, with no zero cycle in between.
- **One-shot total:** `(len+1)·(S+G)·TICK_DIV` cycles from N+1, where S = `max(step_ticks,1)` and G = `gap_ticks`. `busy` falls on the same edge that `done` rises.
- `stop` at edge M: `busy`=0 and `tones`=0 from M+1.
- All outputs are registered except `wr_ready`.

## Structure
- **Package `tone_sequencer_pkg`:**
  - State enum (IDLE/PLAY/GAP).
  - Default `STEPS`/`TICK_DIV` constants.
  - The tone mask width (8), shared with the modulator.
- **Sub-module `tick_gen`:** prescaler with enable and synchronous clear, producing the one-cycle tick.
- Pattern memory is a flop array inside `tone_sequencer`.

## Test plan
All scenarios run with `TICK_DIV`=4.
- **Reset:** assert `rst` mid-PLAY. After the edge: `tones`=0, `busy`=0, `wr_ready`=1, and a readback by playing shows all-zero pattern.
- **One-shot, no gap:**
  - Setup: pattern {0x01,0x02,0x04}, `len`=2, `step_ticks`=2, `gap_ticks`=0, `loop`=0.
  - Response: `tones` = 0x01/0x02/0x04 for 8 cycles each. `done` pulses once at cycle 24 after start. `busy` falls with it.
- **Gap:**
  - Setup: `step_ticks`=1, `gap_ticks`=1, `len`=1, pattern {0x0F,0xF0}.
  - Response: 0x0F×4, 0x00×4, 0xF0×4, 0x00×4, then `done`.
- **Loop and stop:**
  - Setup: `loop`=1, `len`=1.
  - Response: after step 1, `step_idx` returns to 0 with pattern[0]. `stop` asserted mid-step gives `tones`=0 and `busy`=0 on the next cycle, and `done` never pulses.
- **Write handshake:**
  - `wr_valid` held during PLAY: `wr_ready`=0 and memory is unchanged.
  - `start & wr_valid` in the same cycle: the write is refused.
  - A write in IDLE is accepted in one cycle.
- **Edge cases:**
  - `step_ticks`=0 behaves as 1.
  - `start & stop` together: the sequencer stays IDLE.
  - `start` while busy is ignored (`step_idx` is not reset).

Source files
------------

// File: rtl/tone_sequencer_pkg.sv
// rtl/tone_sequencer_pkg.sv - shared types and constants for the tone sequencer
package tone_sequencer_pkg;

  localparam int DEFAULT_STEPS    = 16;
  localparam int DEFAULT_TICK_DIV = 25000;

  // Width of the tone-select bus driven into the modulator stage.
  localparam int TONE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle tick every DIV enabled cycles
module tick_gen #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick is combinational so the consumer acts on the same edge the count wraps.
  assign tick = en && (cnt_q == CW'(DIV - 1));

  // Next count: clear has priority, otherwise count and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - step sequencer playing stored tone masks to the modulator
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int STEPS    = DEFAULT_STEPS,
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  localparam int AW      = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [TONE_W-1:0] wr_data,
  input  logic [AW-1:0]     len,
  input  logic [7:0]        step_ticks,
  input  logic [7:0]        gap_ticks,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic [TONE_W-1:0] tones,
  output logic [AW-1:0]     step_idx,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;

  logic [TONE_W-1:0] mem_q [STEPS];
  logic [TONE_W-1:0] mem_d [STEPS];

  logic [AW-1:0]     len_q, len_d;
  logic [7:0]        step_ticks_q, step_ticks_d;
  logic [7:0]        gap_ticks_q, gap_ticks_d;
  logic              loop_q, loop_d;
  logic [AW-1:0]     step_idx_q, step_idx_d;
  logic [TONE_W-1:0] tones_q, tones_d;
  logic [7:0]        tick_cnt_q, tick_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tick;
  logic              presc_clr;
  logic              advance;
  logic [7:0]        s_eff;
  logic [8:0]        tick_nxt;
  logic              step_last;
  logic              gap_last;
  logic [AW-1:0]     next_idx;

  // Writes are only taken while idle and never in the cycle a start arrives.
  assign wr_ready = (state_q == ST_IDLE) && !start;

  // A programmed step length of zero plays as a single tick.
  assign s_eff     = (step_ticks_q == 8'd0) ? 8'd1 : step_ticks_q;
  assign tick_nxt  = {1'b0, tick_cnt_q} + 9'd1;
  assign step_last = tick_nxt >= {1'b0, s_eff};
  assign gap_last  = tick_nxt >= {1'b0, gap_ticks_q};
  assign next_idx  = step_idx_q + 1'b1;

  assign tones    = tones_q;
  assign step_idx = step_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Pattern memory update from the write port.
  always_comb begin
    mem_d = mem_q;
    if (wr_valid && wr_ready) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Playback state machine: step/gap timing, advance, completion and abort.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    step_ticks_d = step_ticks_q;
    gap_ticks_d  = gap_ticks_q;
    loop_d       = loop_q;
    step_idx_d   = step_idx_q;
    tones_d      = tones_q;
    tick_cnt_d   = tick_cnt_q;
    done_d       = 1'b0;
    presc_clr    = 1'b0;
    advance      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d        = len;
          step_ticks_d = step_ticks;
          gap_ticks_d  = gap_ticks;
          loop_d       = loop;
          step_idx_d   = '0;
          tones_d      = mem_q[0];
          tick_cnt_d   = '0;
          presc_clr    = 1'b1;
          state_d      = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (step_last) begin
            tick_cnt_d = '0;
            if (gap_ticks_q != 8'd0) begin
              state_d = ST_GAP;
              tones_d = '0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_nxt[7:0];
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_last) begin
            tick_cnt_d = '0;
            advance    = 1'b1;
          end else begin
            tick_cnt_d = tick_nxt[7:0];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tones_d = '0;
      end
    endcase

    if (advance) begin
      if (step_idx_q < len_q) begin
        step_idx_d = next_idx;
        tones_d    = mem_q[next_idx];
        state_d    = ST_PLAY;
      end else if (loop_q) begin
        step_idx_d = '0;
        tones_d    = mem_q[0];
        state_d    = ST_PLAY;
      end else begin
        tones_d   = '0;
        done_d    = 1'b1;
        presc_clr = 1'b1;
        state_d   = ST_IDLE;
      end
    end

    // Abort overrides everything, including a start or a completion in the same cycle.
    if (stop) begin
      state_d      = ST_IDLE;
      tones_d      = '0;
      done_d       = 1'b0;
      tick_cnt_d   = '0;
      presc_clr    = 1'b1;
      step_idx_d   = step_idx_q;
      len_d        = len_q;
      step_ticks_d = step_ticks_q;
      gap_ticks_d  = gap_ticks_q;
      loop_d       = loop_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, configuration latches, outputs and pattern memory registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      step_ticks_q <= '0;
      gap_ticks_q  <= '0;
      loop_q       <= 1'b0;
      step_idx_q   <= '0;
      tones_q      <= '0;
      tick_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < STEPS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      step_ticks_q <= step_ticks_d;
      gap_ticks_q  <= gap_ticks_d;
      loop_q       <= loop_d;
      step_idx_q   <= step_idx_d;
      tones_q      <= tones_d;
      tick_cnt_q   <= tick_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_q        <= mem_d;
    end
  end

endmodule
